// File: rtl/ram_pkg.sv
// Shared types and helpers for the clearable parametrised RAM.
// be_merge is shared by the array write path and the read bypass path.
package ram_pkg;

  typedef enum logic [0:0] {IDLE, CLEAR} ram_clr_state_t;

  localparam int RAM_DATA_W     = 64;
  localparam int RAM_ADDR_W     = 8;
  // Widest word be_merge can handle; callers zero-extend and truncate.
  localparam int RAM_MAX_DATA_W = 1024;
  localparam int RAM_MAX_BE_W   = RAM_MAX_DATA_W / 8;

  function automatic logic [RAM_MAX_DATA_W-1:0] be_merge(
    input logic [RAM_MAX_DATA_W-1:0] old_word,
    input logic [RAM_MAX_DATA_W-1:0] new_word,
    input logic [RAM_MAX_BE_W-1:0]   be
  );
    logic [RAM_MAX_DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < RAM_MAX_BE_W; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ram_clr_fsm.sv
// Clear engine: sweeps the whole array writing zeros after reset or clr_req.
// Latency: busy rises on the clr_req edge, falls on the edge writing DEPTH-1.
// Backpressure: none; clr_req while busy is ignored, rst restarts the sweep.
module ram_clr_fsm
  import ram_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_wr,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  ram_clr_state_t state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      clr_addr <= '0;
      busy     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_addr == LAST_ADDR) begin
            state    <= IDLE;
            clr_addr <= '0;
            busy     <= 1'b0;
          end else begin
            clr_addr <= clr_addr + ADDR_W'(1);
          end
        end
      endcase
    end
  end

  assign clr_wr = (state == CLEAR);

endmodule

// File: rtl/ram_param_clr.sv
// Single-port RAM with byte enables and a zeroing clear engine; read latency 1, write latency 0.
// Backpressure: none; accesses are dropped while busy or on a clr_req cycle.
// RAM_PARAM_CLR_WR_BYPASS_EN selects write-first same-cycle reads (default read-first).
module ram_param_clr
  import ram_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W,
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                wrt,
  input  logic [DATA_W/8-1:0] byte_en,
  input  logic                rd_en,
  input  logic                clr_req,
  output logic [DATA_W-1:0]   data_out,
  output logic                data_valid,
  output logic                busy
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_wr;
  logic [ADDR_W-1:0] clr_addr;
  logic              addr_ok;
  logic              accept;
  logic              wr_fire;
  logic              rd_fire;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged_word;
  logic [DATA_W-1:0] rd_word;

  ram_clr_fsm #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clr_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_wr   (clr_wr),
    .clr_addr (clr_addr)
  );

  assign addr_ok = ({1'b0, addr} < DEPTH_L);
  // A clr_req cycle swallows any access issued alongside it.
  assign accept  = !busy && !rst && !clr_req;
  assign wr_fire = accept && wrt && addr_ok;
  assign rd_fire = accept && rd_en;

  assign old_word    = addr_ok ? mem[addr] : '0;
  assign merged_word = DATA_W'(be_merge(RAM_MAX_DATA_W'(old_word),
                                        RAM_MAX_DATA_W'(data_in),
                                        RAM_MAX_BE_W'(byte_en)));

`ifdef RAM_PARAM_CLR_WR_BYPASS_EN
  assign rd_word = !addr_ok ? '0 : (wrt ? merged_word : old_word);
`else
  assign rd_word = old_word;
`endif

  always_ff @(posedge clk) begin
    if (clr_wr) begin
      mem[clr_addr] <= '0;
    end else if (wr_fire) begin
      mem[addr] <= merged_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (rd_fire) begin
      data_out   <= rd_word;
      data_valid <= 1'b1;
    end else begin
      data_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_param_clr.sv
// Randomised bench for ram_param_clr against a byte-level reference memory.
module tb_ram_param_clr;

  localparam int DW    = 64;
  localparam int AW    = 8;
  localparam int DEPTH = 256;
  localparam int BW    = DW / 8;

`ifdef RAM_PARAM_CLR_WR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic          wrt;
  logic [BW-1:0] byte_en;
  logic          rd_en;
  logic          clr_req;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          busy;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] last_out;
  int            n_checks = 0;
  int            n_fail   = 0;

  always #5 clk = ~clk;

  ram_param_clr dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .data_in    (data_in),
    .wrt        (wrt),
    .byte_en    (byte_en),
    .rd_en      (rd_en),
    .clr_req    (clr_req),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy)
  );

  function automatic logic [DW-1:0] ref_merge(input logic [DW-1:0] old_w,
                                              input logic [DW-1:0] new_w,
                                              input logic [BW-1:0] be);
    logic [DW-1:0] r;
    for (int b = 0; b < BW; b++) begin
      r[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wrt = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
    addr = '0; data_in = '0; byte_en = '0;
  endtask

  task automatic ref_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    addr = a; data_in = d; byte_en = be; wrt = 1'b1;
    tick();
    ref_mem[a] = ref_merge(ref_mem[a], d, be);
    wrt = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic v, output logic [DW-1:0] q);
    addr = a; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    v = data_valid; q = data_out;
  endtask

  task automatic count_busy(input int limit, output int n);
    n = 0;
    while (busy === 1'b1 && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    logic v;
    logic [DW-1:0] q;
    logic [AW-1:0] probe [3];
    probe[0] = 8'h00; probe[1] = 8'h7F; probe[2] = 8'hFF;
    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (busy !== 1'b1 || data_valid !== 1'b0 || data_out !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b valid=%b out=%h, expected busy=1 valid=0 out=0", busy, data_valid, data_out);
    end
    rst = 1'b0;
    count_busy(1000, n);
    n_checks++;
    if (n !== DEPTH) begin
      n_fail++;
      $display("FAIL reset_clear_len: busy cycles %0d, expected %0d", n, DEPTH);
    end
    ref_clear();
    last_out = '0;
    for (int i = 0; i < 3; i++) begin
      do_read(probe[i], v, q);
      n_checks++;
      if (v !== 1'b1 || q !== '0) begin
        n_fail++;
        $display("FAIL reset_read_%h: valid=%b data=%h, expected valid=1 data=0", probe[i], v, q);
      end
    end
  endtask

  task automatic test_byte_enables();
    logic v;
    logic [DW-1:0] q;
    do_write(8'h10, 64'h1122334455667788, 8'hFF);
    do_write(8'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    do_write(8'h11, 64'hFFFFFFFFFFFFFFFF, 8'h00);
    do_read(8'h10, v, q);
    n_checks++;
    if (v !== 1'b1 || q !== 64'h11223344AAAAAAAA) begin
      n_fail++;
      $display("FAIL byte_en: valid=%b data=%h, expected valid=1 data=11223344aaaaaaaa", v, q);
    end
    do_read(8'h11, v, q);
    n_checks++;
    if (v !== 1'b1 || q !== 64'h0) begin
      n_fail++;
      $display("FAIL byte_en_zero: valid=%b data=%h, expected valid=1 data=0", v, q);
    end
    last_out = q;
    // Idle cycle after a read: valid drops, data holds.
    tick();
    n_checks++;
    if (data_valid !== 1'b0 || data_out !== last_out) begin
      n_fail++;
      $display("FAIL hold: valid=%b data=%h, expected valid=0 data=%h", data_valid, data_out, last_out);
    end
  endtask

  task automatic test_sweep();
    logic v;
    logic [DW-1:0] q;
    for (int i = 0; i < DEPTH; i++) begin
      do_write(AW'(i), {$urandom, $urandom}, (i % 2 == 0) ? 8'hFF : BW'($urandom));
    end
    for (int i = 0; i < DEPTH; i++) begin
      do_read(AW'(i), v, q);
      n_checks++;
      if (v !== 1'b1 || q !== ref_mem[i]) begin
        n_fail++;
        $display("FAIL sweep_%0d: valid=%b data=%h, expected valid=1 data=%h", i, v, q, ref_mem[i]);
      end
      last_out = q;
    end
  endtask

  task automatic test_same_cycle();
    logic v;
    logic [DW-1:0] q;
    logic [DW-1:0] exp;
    do_write(8'h20, 64'h0, 8'hFF);
    exp = BYPASS ? 64'hDEAD : 64'h0;
    addr = 8'h20; data_in = 64'hDEAD; byte_en = 8'hFF; wrt = 1'b1; rd_en = 1'b1;
    tick();
    wrt = 1'b0; rd_en = 1'b0;
    ref_mem[8'h20] = 64'hDEAD;
    n_checks++;
    if (data_valid !== 1'b1 || data_out !== exp) begin
      n_fail++;
      $display("FAIL same_cycle: valid=%b data=%h, expected valid=1 data=%h", data_valid, data_out, exp);
    end
    do_read(8'h20, v, q);
    n_checks++;
    if (v !== 1'b1 || q !== 64'hDEAD) begin
      n_fail++;
      $display("FAIL same_cycle_after: valid=%b data=%h, expected valid=1 data=dead", v, q);
    end
    last_out = q;
  endtask

  task automatic test_clr_mid_traffic();
    int n;
    int bad_valid;
    logic v;
    logic [DW-1:0] q;
    do_write(8'h05, 64'hCAFEF00DCAFEF00D, 8'hFF);
    addr = 8'h05; data_in = '1; byte_en = 8'hFF; wrt = 1'b1; rd_en = 1'b1; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || data_valid !== 1'b0 || data_out !== last_out) begin
      n_fail++;
      $display("FAIL clr_start: busy=%b valid=%b data=%h, expected busy=1 valid=0 data=%h",
               busy, data_valid, data_out, last_out);
    end
    n = 0;
    bad_valid = 0;
    while (busy === 1'b1 && n < 1000) begin
      addr = AW'($urandom); data_in = {$urandom, $urandom}; byte_en = BW'($urandom);
      wrt = 1'b1; rd_en = 1'($urandom); clr_req = (n == 100);
      tick();
      n++;
      if (data_valid !== 1'b0) bad_valid++;
    end
    idle_inputs();
    n_checks++;
    if (n !== DEPTH) begin
      n_fail++;
      $display("FAIL clr_len: busy cycles %0d, expected %0d", n, DEPTH);
    end
    n_checks++;
    if (bad_valid !== 0 || data_out !== last_out) begin
      n_fail++;
      $display("FAIL clr_busy_access: valid pulses %0d data=%h, expected 0 pulses data=%h",
               bad_valid, data_out, last_out);
    end
    ref_clear();
    for (int i = 0; i < DEPTH; i++) begin
      do_read(AW'(i), v, q);
      n_checks++;
      if (v !== 1'b1 || q !== ref_mem[i]) begin
        n_fail++;
        $display("FAIL clr_zero_%0d: valid=%b data=%h, expected valid=1 data=0", i, v, q);
      end
    end
    last_out = '0;
  endtask

  task automatic test_rst_mid_clear();
    int n;
    logic v;
    logic [DW-1:0] q;
    do_write(8'h33, 64'h0123456789ABCDEF, 8'hFF);
    do_read(8'h33, v, q);
    last_out = q;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    count_busy(128, n);
    n_checks++;
    if (n !== 128 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: busy cycles %0d busy=%b, expected 128 busy=1", n, busy);
    end
    rst = 1'b1; rd_en = 1'b1; addr = 8'h33;
    tick();
    rst = 1'b0; rd_en = 1'b0;
    n_checks++;
    if (data_valid !== 1'b0 || busy !== 1'b1 || data_out !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: valid=%b busy=%b data=%h, expected valid=0 busy=1 data=0",
               data_valid, busy, data_out);
    end
    last_out = '0;
    count_busy(1000, n);
    n_checks++;
    if (n !== DEPTH) begin
      n_fail++;
      $display("FAIL rst_restart_len: busy cycles %0d, expected %0d", n, DEPTH);
    end
    ref_clear();
    do_read(8'h33, v, q);
    n_checks++;
    if (v !== 1'b1 || q !== '0) begin
      n_fail++;
      $display("FAIL rst_zero: valid=%b data=%h, expected valid=1 data=0", v, q);
    end
    last_out = q;
  endtask

  task automatic test_random_traffic();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [BW-1:0] be;
    logic          w;
    logic          r;
    logic [DW-1:0] exp;
    logic [DW-1:0] merged;
    for (int c = 0; c < 600; c++) begin
      a  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      d  = {$urandom, $urandom};
      be = BW'($urandom);
      w  = 1'($urandom);
      r  = 1'($urandom);
      merged = ref_merge(ref_mem[a], d, be);
      exp = (w && BYPASS) ? merged : ref_mem[a];
      addr = a; data_in = d; byte_en = be; wrt = w; rd_en = r;
      tick();
      if (w) ref_mem[a] = merged;
      if (r) last_out = exp;
      n_checks++;
      if (data_valid !== r || data_out !== last_out) begin
        n_fail++;
        $display("FAIL random_%0d: addr=%h valid=%b data=%h, expected valid=%b data=%h",
                 c, a, data_valid, data_out, r, last_out);
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    last_out = '0;
    ref_clear();
    test_reset();
    test_byte_enables();
    test_sweep();
    test_same_cycle();
    test_random_traffic();
    test_clr_mid_traffic();
    test_rst_mid_clear();
    test_random_traffic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
